// File: rtl/xpb_chunk_accum.sv
// Sequences the upper product bits as CHUNK_W-bit indices into the xpb LUT bank and sums the residues onto the base.
// Latency: start accepted to valid_o is NUM_CHUNKS+2 cycles. Throughput is one result per NUM_CHUNKS+2 cycles.
// Backpressure: valid_o/sum_o are held until ack_i. ready_o is low while busy, and a start_i at that time is dropped.
module xpb_chunk_accum #(
  parameter int CHUNK_W    = 5,
  parameter int NUM_CHUNKS = 8,
  parameter int DATA_W     = 1024,
  parameter int SEL_W      = 3,
  parameter int SUM_W      = DATA_W + 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_i,
  output logic                          ready_o,
  input  logic [NUM_CHUNKS*CHUNK_W-1:0] upper_i,
  input  logic [DATA_W-1:0]             base_i,
  output logic [SEL_W-1:0]              lut_sel_o,
  output logic [CHUNK_W-1:0]            lut_idx_o,
  input  logic [DATA_W-1:0]             lut_data_i,
  output logic [SUM_W-1:0]              sum_o,
  output logic                          valid_o,
  input  logic                          ack_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CHUNKS - 1);

  state_t                          state;
  state_t                          state_nxt;
  logic                            accept;
  logic [SEL_W-1:0]                cnt;
  logic [NUM_CHUNKS*CHUNK_W-1:0]   shadow;
  logic [SUM_W-1:0]                acc;
  // The bank registers its output, so a lookup issued this cycle returns data next cycle.
  logic                            issued;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, handshake outputs and LUT address drive.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    lut_sel_o = '0;
    lut_idx_o = '0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        lut_sel_o = cnt;
        lut_idx_o = shadow[cnt*CHUNK_W +: CHUNK_W];
        if (cnt == LAST_SEL) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        // ready_o follows ack_i here so that a new operation can start in the same cycle the result is consumed.
        ready_o = ack_i;
        if (ack_i) begin
          if (start_i) begin
            accept    = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture the operands on accept, step the chunk counter, and accumulate the returned residues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      shadow <= '0;
      acc    <= '0;
      issued <= 1'b0;
    end else begin
      issued <= (state == ISSUE);
      if (accept) begin
        shadow <= upper_i;
        acc    <= {{(SUM_W-DATA_W){1'b0}}, base_i};
        cnt    <= '0;
      end else begin
        if (state == ISSUE) begin
          cnt <= cnt + 1'b1;
        end
        if (issued) begin
          acc <= acc + {{(SUM_W-DATA_W){1'b0}}, lut_data_i};
        end
      end
    end
  end

  assign sum_o = acc;

endmodule

// File: tb/tb_xpb_chunk_accum.sv
// Randomized bench for xpb_chunk_accum, with a registered LUT bank model and a queue scoreboard.
// The expected sum is base plus the sum of LUT(k, chunk k), checked together with latency, sequencing and hold behaviour.
// Acks are delayed at random, stray acks are driven while no result is valid, and the bench also covers busy starts and a reset mid-operation.
module tb_xpb_chunk_accum;

  localparam int CW = 5;
  localparam int NC = 8;
  localparam int DW = 1024;
  localparam int SW = 3;
  localparam int SUMW = DW + 4;
  localparam int LAT = NC + 2;

  typedef struct {
    logic [SUMW-1:0] sum;
    int              cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              ready;
  logic [NC*CW-1:0]  upper = '0;
  logic [DW-1:0]     base = '0;
  logic [SW-1:0]     lut_sel;
  logic [CW-1:0]     lut_idx;
  logic [DW-1:0]     lut_data = '0;
  logic [SUMW-1:0]   sum;
  logic              valid;
  logic              ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int mode = 0;
  int ack_delay = 0;

  exp_t            exp_q[$];
  logic [DW-1:0]   rnd_tab[256];
  logic [NC*CW-1:0] cur_upper = '0;
  int              cur_acc = 0;
  bit              active = 1'b0;

  bit              seen = 1'b0;
  int              hold = 0;
  int              delay = 0;
  logic [SUMW-1:0] held = '0;

  xpb_chunk_accum dut (
    .clk        (clk),
    .reset      (rst),
    .start_i    (start),
    .ready_o    (ready),
    .upper_i    (upper),
    .base_i     (base),
    .lut_sel_o  (lut_sel),
    .lut_idx_o  (lut_idx),
    .lut_data_i (lut_data),
    .sum_o      (sum),
    .valid_o    (valid),
    .ack_i      (ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] lut_f(input int m, input int s, input int i);
    logic [DW-1:0] r;
    case (m)
      0:       r = DW'((s + 1) * i);
      1:       r = '1;
      default: r = rnd_tab[s*32 + i];
    endcase
    return r;
  endfunction

  // The LUT bank registers its output, so data appears one cycle after sel/idx.
  always @(posedge clk) lut_data <= lut_f(mode, int'(lut_sel), int'(lut_idx));

  function automatic logic [SUMW-1:0] ref_sum(input logic [DW-1:0] b, input logic [NC*CW-1:0] u);
    logic [SUMW-1:0] r;
    r = SUMW'(b);
    for (int k = 0; k < NC; k++) begin
      r = r + SUMW'(lut_f(mode, k, int'(u[k*CW +: CW])));
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_wide();
    logic [DW-1:0] r;
    for (int w = 0; w < DW/32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [NC*CW-1:0] rnd_upper();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[NC*CW-1:0];
  endfunction

  task automatic chk(input string name, input logic [SUMW-1:0] got, input logic [SUMW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got hi=%h lo=%h, want hi=%h lo=%h (t=%0t)",
               name, got[SUMW-1:SUMW-36], got[63:0], want[SUMW-1:SUMW-36], want[63:0], $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Drive one start, keep it asserted until ready_o accepts it, then record the expected result.
  task automatic do_op(input logic [DW-1:0] b, input logic [NC*CW-1:0] u);
    int tries;
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    base  = b;
    upper = u;
    #1;
    tries = 0;
    while (!ready && tries < 60) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (!ready) begin
      fail_now("accept_timeout");
      start = 1'b0;
      return;
    end
    e.sum = ref_sum(b, u);
    e.cyc = cyc;
    exp_q.push_back(e);
    cur_upper = u;
    cur_acc   = cyc;
    active    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    base  = rnd_wide();
    upper = rnd_upper();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0 || valid) fail_now("idle_timeout");
    @(negedge clk);
  endtask

  // Monitor: checks LUT sequencing and busy ready_o, pops and compares results, holds and releases ack.
  initial begin
    int d;
    exp_t e;
    logic [SW-1:0] esel;
    logic [CW-1:0] eidx;
    logic [NC*CW-1:0] u;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
        ack  = 1'b0;
      end else begin
        if (active) begin
          d = cyc - cur_acc;
          if (d >= 1 && d <= LAT - 1) begin
            u = cur_upper;
            esel = (d <= NC) ? SW'(d - 1) : '0;
            eidx = (d <= NC) ? u[(d-1)*CW +: CW] : '0;
            chk("busy_ready", SUMW'(ready), '0);
            chk("lut_sel", SUMW'(lut_sel), SUMW'(esel));
            chk("lut_idx", SUMW'(lut_idx), SUMW'(eidx));
          end
        end
        if (valid) begin
          if (!seen) begin
            if (exp_q.size() == 0) begin
              fail_now("unexpected_valid");
            end else begin
              e = exp_q.pop_front();
              chk("sum", sum, e.sum);
              chk("latency", SUMW'(cyc - e.cyc), SUMW'(LAT));
            end
            held  = sum;
            seen  = 1'b1;
            hold  = 0;
            delay = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
          end else begin
            chk("sum_stable", sum, held);
          end
          chk("done_ready", SUMW'(ready), SUMW'(ack));
          ack = (hold >= delay);
          hold++;
        end else begin
          seen = 1'b0;
          ack  = ($urandom_range(0, 3) == 0);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) rnd_tab[i] = rnd_wide();

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", SUMW'(ready), SUMW'(1));
    chk("rst_valid", SUMW'(valid), '0);
    chk("rst_sum", sum, '0);
    chk("rst_sel", SUMW'(lut_sel), '0);
    chk("rst_idx", SUMW'(lut_idx), '0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Zero reduce, then the full sum 100 + 31*36.
    mode = 0;
    ack_delay = 0;
    do_op(DW'(1), '0);
    do_op(DW'(100), {NC{5'h1f}});
    wait_idle();

    // Width: every term all-ones, so the top 4 bits must carry.
    mode = 1;
    do_op('1, rnd_upper() | 40'h1);
    wait_idle();

    // Hold ack low for 5 cycles, then a back-to-back start in the ack cycle.
    mode = 2;
    ack_delay = 5;
    do_op(rnd_wide(), rnd_upper());
    do_op(rnd_wide(), rnd_upper());
    wait_idle();
    ack_delay = -1;

    // Start while busy is dropped.
    do_op(rnd_wide(), rnd_upper());
    repeat (4) @(negedge clk);
    start = 1'b1;
    base  = rnd_wide();
    upper = rnd_upper();
    #1;
    chk("busy_start_ready", SUMW'(ready), '0);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // Reset mid-operation.
    do_op(rnd_wide(), rnd_upper());
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    active = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("mid_rst_ready", SUMW'(ready), SUMW'(1));
    chk("mid_rst_valid", SUMW'(valid), '0);
    chk("mid_rst_sum", sum, '0);
    chk("mid_rst_sel", SUMW'(lut_sel), '0);
    chk("mid_rst_idx", SUMW'(lut_idx), '0);
    @(negedge clk);
    #2 rst = 1'b0;
    do_op(rnd_wide(), rnd_upper());
    wait_idle();

    // Random traffic with random ack delays and back-to-back requests.
    for (int n = 0; n < 20; n++) begin
      do_op(rnd_wide(), ($urandom_range(0, 4) == 0) ? '0 : rnd_upper());
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    wait_idle();
    chk("queue_empty", SUMW'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
